// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side responder for the processor8bit memory bus.
// Holds a 2^AW x DW RAM. Reads drive the shared tri-state dat bus, and writes commit data sampled from dat.
// Supports optional wait states, a side-band preload port, a sticky conflict flag and activity counters.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   add, rd, wrt    bus address and read/write strobes from the processor
//   dat             shared data bus, driven here only during a read response
//   rdy             transfer-complete strobe
//   ld_en/addr/data preload write port (highest priority)
//   err, err_clr    sticky rd&wrt conflict flag and its synchronous clear
//   rd_cnt, wr_cnt  completed read/write counters (wrap modulo 2^CNT_W)
`timescale 1ns/1ps
module bus_mem_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    add,
  inout  wire  [DW-1:0]    dat,
  input  logic             rd,
  input  logic             wrt,
  output logic             rdy,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DW-1:0]    ld_data,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic             conflict_c;
  logic             rd_inc_c, wr_inc_c;
  logic             bus_we_c;
  logic [AW-1:0]    bus_waddr_c;
  logic [DW-1:0]    bus_wdata_c;
  logic             oe_c;
  logic [DW-1:0]    rdata_c;
  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c;
  logic [DW-1:0]    mem_wdata_c;

  // Preload masks the bus entirely, so a conflict only counts when ld_en is low
  assign conflict_c = rd & wrt & ~ld_en;

  // Shared bus driver; released whenever no read response is active
  assign dat = oe_c ? rdata_c : {DW{1'bz}};

  if (WAIT_STATES == 0) begin : g_zero_wait
    logic rdy_c;

    // Zero-wait: response and write strobe follow the request combinationally
    always_comb begin
      rdy_c       = 1'b0;
      oe_c        = 1'b0;
      rd_inc_c    = 1'b0;
      wr_inc_c    = 1'b0;
      bus_we_c    = 1'b0;
      bus_waddr_c = add;
      bus_wdata_c = dat;
      if (!rst && !ld_en && (rd ^ wrt)) begin
        rdy_c = 1'b1;
        if (rd) begin
          oe_c     = 1'b1;
          rd_inc_c = 1'b1;
        end else begin
          bus_we_c = 1'b1;
          wr_inc_c = 1'b1;
        end
      end
    end

    assign rdy     = rdy_c;
    assign rdata_c = mem_q[add];

  end else begin : g_wait
    localparam int unsigned WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           op_wr_q, op_wr_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           rdy_q, rdy_d;
    logic           oe_q, oe_d;

    // Transfer state register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        wcnt_q  <= '0;
        addr_q  <= '0;
        op_wr_q <= 1'b0;
        rdata_q <= '0;
        rdy_q   <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        addr_q  <= addr_d;
        op_wr_q <= op_wr_d;
        rdata_q <= rdata_d;
        rdy_q   <= rdy_d;
        oe_q    <= oe_d;
      end
    end

    // Next state; rdy/oe are set on entry to ACK so they are registered for the ACK cycle
    always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      addr_d      = addr_q;
      op_wr_d     = op_wr_q;
      rdata_d     = rdata_q;
      rdy_d       = 1'b0;
      oe_d        = 1'b0;
      rd_inc_c    = 1'b0;
      wr_inc_c    = 1'b0;
      bus_we_c    = 1'b0;
      bus_waddr_c = addr_q;
      bus_wdata_c = dat;
      if (ld_en || conflict_c) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rd ^ wrt) begin
              addr_d  = add;
              op_wr_d = wrt;
              wcnt_d  = WCW'(WAIT_STATES - 1);
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (op_wr_q ? !wrt : !rd) begin
              state_d = S_IDLE;
            end else if (wcnt_q == '0) begin
              state_d = S_ACK;
              rdy_d   = 1'b1;
              oe_d    = !op_wr_q;
              if (!op_wr_q) begin
                rdata_d = mem_q[addr_q];
              end
            end else begin
              wcnt_d = wcnt_q - WCW'(1);
            end
          end
          S_ACK: begin
            // Write data is taken at the closing edge of ACK
            state_d = S_IDLE;
            if (op_wr_q) begin
              bus_we_c = 1'b1;
              wr_inc_c = 1'b1;
            end else begin
              rd_inc_c = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Preload masks the response immediately, without waiting for the state to drop
    assign rdy     = rdy_q & ~ld_en;
    assign oe_c    = oe_q & ~ld_en;
    assign rdata_c = rdata_q;
  end

  // RAM write port: preload wins over bus writes
  always_comb begin
    mem_we_c    = ld_en | bus_we_c;
    mem_waddr_c = ld_en ? ld_addr : bus_waddr_c;
    mem_wdata_c = ld_en ? ld_data : bus_wdata_c;
  end

  // RAM contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Sticky error and activity counters; a new conflict beats err_clr
  always_comb begin
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (conflict_c) begin
      err_d = 1'b1;
    end
    if (rd_inc_c) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (wr_inc_c) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Testbench for bus_mem_responder: zero-wait instance (CNT_W=4) driven from a vector table,
// and wait-state instances (N=2, N=3) exercised by hand-written sequences with a read-data scoreboard.
`timescale 1ns/1ps
module tb_bus_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] add, ld_addr, ld_data, tb_dat;
  logic       rd, wrt, ld_en, err_clr, tb_oe;

  // Pulled-up buses so a released bus reads as all ones
  tri1 [7:0]  dat0, dat2, dat3;

  logic        u0_rdy, u0_err, u2_rdy, u2_err, u3_rdy, u3_err;
  logic [3:0]  u0_rc, u0_wc;
  logic [15:0] u2_rc, u2_wc, u3_rc, u3_wc;

  assign dat0 = tb_oe ? tb_dat : 8'bz;
  assign dat2 = tb_oe ? tb_dat : 8'bz;
  assign dat3 = tb_oe ? tb_dat : 8'bz;

  always #5 clk = ~clk;

  bus_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .add(add), .dat(dat0), .rd(rd), .wrt(wrt), .rdy(u0_rdy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(u0_err), .err_clr(err_clr),
    .rd_cnt(u0_rc), .wr_cnt(u0_wc));

  bus_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .add(add), .dat(dat2), .rd(rd), .wrt(wrt), .rdy(u2_rdy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(u2_err), .err_clr(err_clr),
    .rd_cnt(u2_rc), .wr_cnt(u2_wc));

  bus_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .add(add), .dat(dat3), .rd(rd), .wrt(wrt), .rdy(u3_rdy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(u3_err), .err_clr(err_clr),
    .rd_cnt(u3_rc), .wr_cnt(u3_wc));

  typedef struct {
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       rd;
    logic       wrt;
    logic [7:0] add;
    logic       oe;
    logic [7:0] wdat;
    logic       clr;
    logic       exp_rdy;
    logic       exp_drv;
    logic [7:0] exp_dat;
    logic       exp_err;
    logic [3:0] exp_rc;
    logic [3:0] exp_wc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic vec_t mk(logic l, logic [7:0] la, logic [7:0] ld, logic r, logic w,
                              logic [7:0] a, logic o, logic [7:0] wd, logic c, logic erdy,
                              logic edrv, logic [7:0] edat, logic eerr, logic [3:0] erc,
                              logic [3:0] ewc);
    vec_t v;
    v.ld_en = l;    v.ld_addr = la;   v.ld_data = ld;   v.rd = r;       v.wrt = w;
    v.add = a;      v.oe = o;         v.wdat = wd;      v.clr = c;      v.exp_rdy = erdy;
    v.exp_drv = edrv; v.exp_dat = edat; v.exp_err = eerr; v.exp_rc = erc; v.exp_wc = ewc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Released bus: pulled-up value (00 accepted where a tool lacks pull support)
  task automatic chk_rel(input string name, input logic [7:0] act);
    n_vec++;
    if (!(act === 8'hFF || act === 8'h00)) begin
      n_bad++;
      $display("FAIL %s: got %0h expected released bus at %0t", name, act, $time);
    end
  endtask

  task automatic sb_check(input string name, input logic [7:0] act);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got %0h with no expected read data queued", name, act);
    end else begin
      exp = sb_q.pop_front();
      chk(name, 32'(act), 32'(exp));
    end
  endtask

  task automatic bus_idle();
    rd = 1'b0; wrt = 1'b0; tb_oe = 1'b0; ld_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Index (0 = request edge E0) of the first edge after which rdy is seen; -1 on timeout
  task automatic wait_rdy(input int which, output int lat);
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if ((which == 2) ? u2_rdy : u3_rdy) begin
        lat = k;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1; add = '0; ld_addr = '0; ld_data = '0; tb_dat = '0;
    bus_idle();

    // Reset state of all instances
    @(negedge clk);
    chk("rst_u0_rdy", 32'(u0_rdy), 32'd0);
    chk("rst_u0_err", 32'(u0_err), 32'd0);
    chk("rst_u0_rc", 32'(u0_rc), 32'd0);
    chk("rst_u0_wc", 32'(u0_wc), 32'd0);
    chk("rst_u2_rdy", 32'(u2_rdy), 32'd0);
    chk("rst_u2_err", 32'(u2_err), 32'd0);
    chk("rst_u2_cnt", 32'({u2_rc, u2_wc}), 32'd0);
    chk("rst_u3_rdy", 32'(u3_rdy), 32'd0);
    chk("rst_u3_err", 32'(u3_err), 32'd0);
    chk("rst_u3_cnt", 32'({u3_rc, u3_wc}), 32'd0);
    chk_rel("rst_dat0", dat0);
    chk_rel("rst_dat2", dat2);
    chk_rel("rst_dat3", dat3);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait vector table:  ld  ld_a   ld_d   rd    wrt   add    oe    wdat   clr | rdy drv dat err rc wc
    vecs.push_back(mk(1'b1, 8'h45, 8'h3C, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0));
    vecs.push_back(mk(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 4'd1, 4'd0));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 4'd2, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd2, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 4'd3, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd4, 4'd1));
    // Twelve more reads take the 4-bit read counter through 15 and back to 0
    for (int i = 0; i < 12; i++) begin
      vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 4'(5 + i), 4'd1));
    end
    vecs.push_back(mk(1'b1, 8'h20, 8'h5A, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd1));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 4'd1, 4'd1));

    foreach (vecs[i]) begin
      @(negedge clk);
      ld_en = vecs[i].ld_en; ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
      rd = vecs[i].rd; wrt = vecs[i].wrt; add = vecs[i].add;
      tb_oe = vecs[i].oe; tb_dat = vecs[i].wdat; err_clr = vecs[i].clr;
      #2;
      chk($sformatf("v%0d_rdy", i), 32'(u0_rdy), 32'(vecs[i].exp_rdy));
      if (!vecs[i].oe) begin
        if (vecs[i].exp_drv) chk($sformatf("v%0d_dat", i), 32'(dat0), 32'(vecs[i].exp_dat));
        else chk_rel($sformatf("v%0d_dat", i), dat0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_err", i), 32'(u0_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rc", i), 32'(u0_rc), 32'(vecs[i].exp_rc));
      chk($sformatf("v%0d_wc", i), 32'(u0_wc), 32'(vecs[i].exp_wc));
    end

    // Two wait states: latency, latched address, single-cycle ACK with rd still held
    do_reset();
    preload(8'h91, 8'h11);
    rd = 1'b1; add = 8'h91;
    sb_q.push_back(8'h11);
    @(posedge clk);
    #1;
    chk("t3_e0_rdy", 32'(u2_rdy), 32'd0);
    add = 8'h10;
    wait_rdy(2, lat);
    chk("t3_latency", 32'(lat + 1), 32'd2);
    sb_check("t3_dat", dat2);
    @(posedge clk);
    #1;
    chk("t3_ack_end_rdy", 32'(u2_rdy), 32'd0);
    chk_rel("t3_ack_end_dat", dat2);
    chk("t3_rc", 32'(u2_rc), 32'd1);
    @(negedge clk);
    rd = 1'b0;

    // Three wait states: aborted write leaves RAM and counter untouched
    do_reset();
    preload(8'h82, 8'hC3);
    wrt = 1'b1; add = 8'h82; tb_oe = 1'b1; tb_dat = 8'h99;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wrt = 1'b0; tb_oe = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (u3_rdy) seen = 1'b1;
    end
    chk("t5_abort_rdy", 32'(seen), 32'd0);
    chk("t5_abort_wc", 32'(u3_wc), 32'd0);

    // Read back the untouched word; rd dropped during ACK still completes
    @(negedge clk);
    rd = 1'b1; add = 8'h82;
    sb_q.push_back(8'hC3);
    wait_rdy(3, lat);
    chk("t5_rd_latency", 32'(lat), 32'd3);
    sb_check("t5_rd_dat", dat3);
    @(negedge clk);
    rd = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rd_rc", 32'(u3_rc), 32'd1);
    chk_rel("t5_rd_after_dat", dat3);

    // Write data is taken at the end of ACK, not at the request
    @(negedge clk);
    wrt = 1'b1; add = 8'h84; tb_oe = 1'b1; tb_dat = 8'h00;
    wait_rdy(3, lat);
    chk("t5_wr_latency", 32'(lat), 32'd3);
    @(negedge clk);
    tb_dat = 8'h6D;
    @(posedge clk);
    #1;
    chk("t5_wr_wc", 32'(u3_wc), 32'd1);
    @(negedge clk);
    wrt = 1'b0; tb_oe = 1'b0;
    rd = 1'b1; add = 8'h84;
    sb_q.push_back(8'h6D);
    wait_rdy(3, lat);
    chk("t5_wrbk_latency", 32'(lat), 32'd3);
    sb_check("t5_wrbk_dat", dat3);
    @(negedge clk);
    rd = 1'b0;

    // Reset during ACK releases the bus at once
    @(negedge clk);
    rd = 1'b1; add = 8'h82;
    sb_q.push_back(8'hC3);
    wait_rdy(3, lat);
    chk("t5_rst_latency", 32'(lat), 32'd3);
    sb_check("t5_rst_dat", dat3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ack_rdy", 32'(u3_rdy), 32'd0);
    chk_rel("t5_rst_ack_dat", dat3);
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT discards the pending read
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_wait_rdy", 32'(u3_rdy), 32'd0);
    chk_rel("t5_rst_wait_dat", dat3);
    @(negedge clk);
    rst = 1'b0; rd = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (u3_rdy) seen = 1'b1;
    end
    chk("t5_discard_rdy", 32'(seen), 32'd0);
    chk("t5_discard_rc", 32'(u3_rc), 32'd0);
    chk("t5_discard_wc", 32'(u3_wc), 32'd0);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
